// File: rtl/ball_engine_if.sv
// rtl/ball_engine_if.sv - ball engine control inputs and ball/score outputs
interface ball_engine_if #(parameter int SCORE_W = 4);
  logic               in_ani_stb;
  logic               in_animate;
  logic               in_start;
  logic [11:0]        in_leftbar_top;
  logic [11:0]        in_rightbar_top;
  logic [11:0]        out_x1;
  logic [11:0]        out_x2;
  logic [11:0]        out_y1;
  logic [11:0]        out_y2;
  logic               out_left_score;
  logic               out_right_score;
  logic [SCORE_W-1:0] out_left_points;
  logic [SCORE_W-1:0] out_right_points;
  logic [3:0]         out_speed;
  logic [1:0]         out_state;
  logic               out_game_over;
  logic               out_winner;

  modport master (
    output in_ani_stb, in_animate, in_start, in_leftbar_top, in_rightbar_top,
    input  out_x1, out_x2, out_y1, out_y2, out_left_score, out_right_score,
           out_left_points, out_right_points, out_speed, out_state,
           out_game_over, out_winner
  );

  modport slave (
    input  in_ani_stb, in_animate, in_start, in_leftbar_top, in_rightbar_top,
    output out_x1, out_x2, out_y1, out_y2, out_left_score, out_right_score,
           out_left_points, out_right_points, out_speed, out_state,
           out_game_over, out_winner
  );
endinterface

// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - match-level pong ball engine: serve, paddle/wall collisions, scoring
module ball_engine #(
  parameter int          H_SIZE        = 10,
  parameter int          V_SIZE        = 10,
  parameter int          IX            = 320,
  parameter int          IY            = 240,
  parameter int          BAR_WIDTH     = 20,
  parameter int          BAR_LENGTH    = 180,
  parameter int          D_WIDTH       = 639,
  parameter int          D_HEIGHT      = 470,
  parameter int          SPEED_MIN     = 2,
  parameter int          SPEED_MAX     = 6,
  parameter int          HITS_PER_STEP = 4,
  parameter int          SERVE_FRAMES  = 60,
  parameter int          WIN_POINTS    = 5,
  parameter int          SCORE_W       = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic          in_clock,
  input logic          in_reset_n,
  ball_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam logic [11:0]        X_SERVE    = 12'(IX);
  localparam logic [11:0]        Y_SERVE    = 12'(IY);
  localparam logic [11:0]        Y_LO       = 12'(V_SIZE);
  localparam logic [11:0]        Y_HI       = 12'(D_HEIGHT - 1 - V_SIZE);
  localparam logic [12:0]        H13        = 13'(H_SIZE);
  localparam logic [12:0]        V13        = 13'(V_SIZE);
  localparam logic [12:0]        LZONE      = 13'(BAR_WIDTH);
  localparam logic [12:0]        RZONE      = 13'(D_WIDTH - BAR_WIDTH);
  localparam logic [12:0]        BL         = 13'(BAR_LENGTH);
  localparam logic [12:0]        BL_1_3     = 13'(BAR_LENGTH / 3);
  localparam logic [12:0]        BL_2_3     = 13'(2 * BAR_LENGTH / 3);
  localparam logic [3:0]         SPD_LO     = 4'(SPEED_MIN);
  localparam logic [3:0]         SPD_HI     = 4'(SPEED_MAX);
  localparam logic [7:0]         HITS_N     = 8'(HITS_PER_STEP);
  localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_N      = SCORE_W'(WIN_POINTS);
  localparam logic [SCORE_W-1:0] ONE_PT     = SCORE_W'(1);

  state_t             state_q, state_d;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic               x_dir_q, x_dir_d, y_dir_q, y_dir_d, y_mov_q, y_mov_d;
  logic [3:0]         speed_q, speed_d;
  logic [7:0]         hits_q, hits_d;
  logic [15:0]        serve_q, serve_d;
  logic [SCORE_W-1:0] lpts_q, lpts_d, rpts_q, rpts_d;
  logic               lpulse_q, lpulse_d, rpulse_q, rpulse_d, winner_q, winner_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic        frame_step, left_zone, right_zone, miss, outer, point;
  logic [12:0] x1e, x2e, y1e, y2e, top13, sp13;
  logic [11:0] sp12;

  assign frame_step = bus.in_ani_stb & bus.in_animate;
  assign x1e        = {1'b0, x_q} - H13;
  assign x2e        = {1'b0, x_q} + H13;
  assign y1e        = {1'b0, y_q} - V13;
  assign y2e        = {1'b0, y_q} + V13;
  assign sp12       = {8'd0, speed_q};
  assign sp13       = {9'd0, speed_q};
  assign left_zone  = x1e < LZONE;
  assign right_zone = x2e > RZONE;
  assign top13      = {1'b0, left_zone ? bus.in_leftbar_top : bus.in_rightbar_top};
  assign miss       = (y1e > top13 + BL) || (y2e < top13);
  assign outer      = (y2e < top13 + BL_1_3) || (y1e > top13 + BL_2_3);

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state_q  <= IDLE;
      x_q      <= X_SERVE;
      y_q      <= Y_SERVE;
      x_dir_q  <= 1'b0;
      y_dir_q  <= 1'b0;
      y_mov_q  <= 1'b1;
      speed_q  <= SPD_LO;
      hits_q   <= '0;
      serve_q  <= '0;
      lpts_q   <= '0;
      rpts_q   <= '0;
      lpulse_q <= 1'b0;
      rpulse_q <= 1'b0;
      winner_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x_dir_q  <= x_dir_d;
      y_dir_q  <= y_dir_d;
      y_mov_q  <= y_mov_d;
      speed_q  <= speed_d;
      hits_q   <= hits_d;
      serve_q  <= serve_d;
      lpts_q   <= lpts_d;
      rpts_q   <= rpts_d;
      lpulse_q <= lpulse_d;
      rpulse_q <= rpulse_d;
      winner_q <= winner_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x_dir_d  = x_dir_q;
    y_dir_d  = y_dir_q;
    y_mov_d  = y_mov_q;
    speed_d  = speed_q;
    hits_d   = hits_q;
    serve_d  = serve_q;
    lpts_d   = lpts_q;
    rpts_d   = rpts_q;
    lpulse_d = 1'b0;
    rpulse_d = 1'b0;
    winner_d = winner_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    point    = 1'b0;

    if (bus.in_start) begin
      state_d = SERVE;
      x_d     = X_SERVE;
      y_d     = Y_SERVE;
      x_dir_d = lfsr_q[0];
      y_dir_d = lfsr_q[1];
      y_mov_d = 1'b1;
      speed_d = SPD_LO;
      hits_d  = '0;
      serve_d = '0;
      lpts_d  = '0;
      rpts_d  = '0;
    end else if (frame_step) begin
      case (state_q)
        SERVE: begin
          if (serve_q == SERVE_LAST) state_d = PLAY;
          else                       serve_d = serve_q + 16'd1;
        end
        PLAY: begin
          if (left_zone || right_zone) begin
            if (miss) begin
              // Point: re-serve toward the side that just conceded.
              point   = 1'b1;
              x_d     = X_SERVE;
              y_d     = Y_SERVE;
              speed_d = SPD_LO;
              hits_d  = '0;
              y_mov_d = 1'b1;
              y_dir_d = lfsr_q[1];
              serve_d = '0;
              state_d = SERVE;
              if (left_zone) begin
                rpts_d   = rpts_q + ONE_PT;
                rpulse_d = 1'b1;
                x_dir_d  = 1'b1;
                if (rpts_q + ONE_PT == WIN_N) begin
                  state_d  = OVER;
                  winner_d = 1'b1;
                end
              end else begin
                lpts_d   = lpts_q + ONE_PT;
                lpulse_d = 1'b1;
                x_dir_d  = 1'b0;
                if (lpts_q + ONE_PT == WIN_N) begin
                  state_d  = OVER;
                  winner_d = 1'b0;
                end
              end
            end else begin
              x_dir_d = ~left_zone;
              if (outer) begin
                y_dir_d = lfsr_q[1];
                y_mov_d = 1'b1;
              end else begin
                y_mov_d = 1'b0;
              end
              if (hits_q + 8'd1 == HITS_N) begin
                hits_d = '0;
                if (speed_q < SPD_HI) speed_d = speed_q + 4'd1;
              end else begin
                hits_d = hits_q + 8'd1;
              end
            end
          end
          // Move with the post-collision direction; clamps compare in 13 bits so up-moves never wrap.
          if (!point) begin
            x_d = x_dir_d ? x_q - sp12 : x_q + sp12;
            if (y_mov_d) begin
              if (y_dir_d) begin
                if ({1'b0, y_q} < sp13 + {1'b0, Y_LO}) begin
                  y_d     = Y_LO;
                  y_dir_d = 1'b0;
                end else begin
                  y_d = y_q - sp12;
                end
              end else begin
                if ({1'b0, y_q} + sp13 > {1'b0, Y_HI}) begin
                  y_d     = Y_HI;
                  y_dir_d = 1'b1;
                end else begin
                  y_d = y_q + sp12;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_x1           = x1e[11:0];
  assign bus.out_x2           = x2e[11:0];
  assign bus.out_y1           = y1e[11:0];
  assign bus.out_y2           = y2e[11:0];
  assign bus.out_left_score   = lpulse_q;
  assign bus.out_right_score  = rpulse_q;
  assign bus.out_left_points  = lpts_q;
  assign bus.out_right_points = rpts_q;
  assign bus.out_speed        = speed_q;
  assign bus.out_state        = state_q;
  assign bus.out_game_over    = (state_q == OVER);
  assign bus.out_winner       = winner_q;
endmodule
